// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Time-shares one external combinational adder between N_REQ requesters.
// The arbiter picks one requester round-robin. It registers that requester's
// operands onto the adder inputs and gives the adder one full cycle to settle.
// It then registers the sum and carry and holds them on a valid/ready result
// port until the consumer accepts them.
module adder_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int W     = 16,
    parameter int IDW   = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    input  logic [N_REQ-1:0]   req_cin,
    output logic [W-1:0]       add_a,
    output logic [W-1:0]       add_b,
    output logic               add_cin,
    input  logic [W-1:0]       add_sum,
    input  logic               add_cout,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [W-1:0]       res_sum,
    output logic               res_cout,
    output logic [IDW-1:0]     res_id,
    output logic               busy,
    output logic [15:0]        ops_done
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One extra bit so that rr_ptr + offset cannot overflow before the modulo.
    localparam int PW = IDW + 1;
    localparam logic [PW-1:0]  N_REQ_P  = PW'(N_REQ);
    localparam logic [IDW-1:0] LAST_IDX = IDW'(N_REQ - 1);

    state_t           state_reg;
    logic [IDW-1:0]   rr_ptr_reg;
    logic [IDW-1:0]   grant_id_reg;
    logic [W-1:0]     add_a_reg;
    logic [W-1:0]     add_b_reg;
    logic             add_cin_reg;
    logic             res_valid_reg;
    logic [W-1:0]     res_sum_reg;
    logic             res_cout_reg;
    logic [IDW-1:0]   res_id_reg;
    logic             busy_reg;
    logic [15:0]      ops_done_reg;

    // Unpacked views of the packed operand buses, one entry per requester.
    logic [W-1:0]     op_a_arr [N_REQ];
    logic [W-1:0]     op_b_arr [N_REQ];

    // scan_idx[k] is the requester index visited at priority position k.
    // Position 0 is rr_ptr itself.
    logic [IDW-1:0]   scan_idx [N_REQ];
    logic [N_REQ-1:0] scan_valid;

    logic             pick_found;
    logic [IDW-1:0]   pick_idx;
    logic             grant_en;
    logic [IDW-1:0]   ptr_next;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
            logic [PW-1:0] wrap_sum;

            assign op_a_arr[gi] = req_a[gi*W +: W];
            assign op_b_arr[gi] = req_b[gi*W +: W];

            // rr_ptr < N_REQ and gi < N_REQ, so one conditional subtract
            // gives the modulo.
            assign wrap_sum       = {1'b0, rr_ptr_reg} + PW'(gi);
            assign scan_idx[gi]   = (wrap_sum >= N_REQ_P) ? IDW'(wrap_sum - N_REQ_P)
                                                          : wrap_sum[IDW-1:0];
            assign scan_valid[gi] = req_valid[scan_idx[gi]];
        end
    endgenerate

    // Find the first valid requester in rotated order.
    // Scanning downwards lets the lowest position win.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (scan_valid[k]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx[k];
            end
        end
    end

    // A grant is only offered while idle and outside reset.
    // The offer is therefore also the handshake.
    assign grant_en = (state_reg == ST_IDLE) && !rst && pick_found;
    assign ptr_next = (pick_idx == LAST_IDX) ? '0 : pick_idx + IDW'(1);

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
            assign req_ready[gi] = grant_en && (pick_idx == IDW'(gi));
        end
    endgenerate

    // Sequencer: capture operands on grant, then wait one settle cycle.
    // Capture the adder result, then hold it until it is accepted.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            rr_ptr_reg    <= '0;
            grant_id_reg  <= '0;
            add_a_reg     <= '0;
            add_b_reg     <= '0;
            add_cin_reg   <= 1'b0;
            res_valid_reg <= 1'b0;
            res_sum_reg   <= '0;
            res_cout_reg  <= 1'b0;
            res_id_reg    <= '0;
            busy_reg      <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (pick_found) begin
                        add_a_reg    <= op_a_arr[pick_idx];
                        add_b_reg    <= op_b_arr[pick_idx];
                        add_cin_reg  <= req_cin[pick_idx];
                        grant_id_reg <= pick_idx;
                        rr_ptr_reg   <= ptr_next;
                        busy_reg     <= 1'b1;
                        state_reg    <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    // The adder inputs have been stable for a full cycle here.
                    res_sum_reg   <= add_sum;
                    res_cout_reg  <= add_cout;
                    res_id_reg    <= grant_id_reg;
                    res_valid_reg <= 1'b1;
                    state_reg     <= ST_DONE;
                end
                ST_DONE: begin
                    if (res_ready) begin
                        res_valid_reg <= 1'b0;
                        busy_reg      <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: begin
                    res_valid_reg <= 1'b0;
                    busy_reg      <= 1'b0;
                    state_reg     <= ST_IDLE;
                end
            endcase
        end
    end

    // Count accepted results; the counter wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            ops_done_reg <= '0;
        end else if (res_valid_reg && res_ready) begin
            ops_done_reg <= ops_done_reg + 16'd1;
        end
    end

    assign add_a     = add_a_reg;
    assign add_b     = add_b_reg;
    assign add_cin   = add_cin_reg;
    assign res_valid = res_valid_reg;
    assign res_sum   = res_sum_reg;
    assign res_cout  = res_cout_reg;
    assign res_id    = res_id_reg;
    assign busy      = busy_reg;
    assign ops_done  = ops_done_reg;

endmodule
